// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1-style framing, mid-bit sampling
//
// Purpose: receives start / DATA_LEN data bits (LSB first) / stop frames from
// an asynchronous serial line and presents each word in parallel with a
// one-cycle done strobe.
//
// Optional feature macro: UART_RX_FRAME_CHECK_EN
//   defined   : a bad (low) stop bit suppresses the update and pulses o_frame_err
//   undefined : the stop-bit value is ignored and every frame is delivered
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_rx_line    asynchronous serial input, idles high
//   o_rx_data    last correctly received word, held until the next one
//   o_rx_done    one-cycle strobe when o_rx_data has been updated
//   o_rx_busy    high from start detect through the stop bit
//   o_frame_err  (UART_RX_FRAME_CHECK_EN only) one-cycle bad-stop-bit strobe

module uart_rx #(
    parameter int DATA_LEN     = 8,
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_rx_line,
    output logic [DATA_LEN-1:0] o_rx_data,
    output logic                o_rx_done,
    output logic                o_rx_busy
`ifdef UART_RX_FRAME_CHECK_EN
    ,
    output logic                o_frame_err
`endif
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic [CNT_W-1:0]    r_clk_count;
    logic [BIT_W-1:0]    r_bit_count;
    logic [DATA_LEN-1:0] r_shift;
    logic [DATA_LEN-1:0] r_rx_data;
    logic                r_rx_done;
    logic                r_rx_busy;
`ifdef UART_RX_FRAME_CHECK_EN
    logic                r_frame_err;
`endif

    logic w_rx_sync;

    assign w_rx_sync = r_sync2;

    assign o_rx_data = r_rx_data;
    assign o_rx_done = r_rx_done;
    assign o_rx_busy = r_rx_busy;
`ifdef UART_RX_FRAME_CHECK_EN
    assign o_frame_err = r_frame_err;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // Synchronizer resets to the idle line level so reset release
            // cannot look like a start bit.
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= S_IDLE;
            r_clk_count <= '0;
            r_bit_count <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_done   <= 1'b0;
            r_rx_busy   <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_sync1 <= i_rx_line;
            r_sync2 <= r_sync1;

            case (r_state)
                S_IDLE: begin
                    r_rx_done   <= 1'b0;
                    r_rx_busy   <= 1'b0;
                    r_clk_count <= '0;
                    r_bit_count <= '0;
                    if (!w_rx_sync) begin
                        r_state   <= S_START;
                        r_rx_busy <= 1'b1;
                    end
                end

                // Re-check the line half a bit in; from here on every sample
                // lands one full bit period later, i.e. mid-bit.
                S_START: begin
                    if (r_clk_count == HALF_CNT) begin
                        r_clk_count <= '0;
                        if (!w_rx_sync) begin
                            r_state     <= S_DATA;
                            r_bit_count <= '0;
                        end else begin
                            r_state   <= S_IDLE;
                            r_rx_busy <= 1'b0;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_clk_count == LAST_CNT) begin
                        r_clk_count          <= '0;
                        r_shift[r_bit_count] <= w_rx_sync;
                        if (r_bit_count == LAST_BIT) begin
                            r_bit_count <= '0;
                            r_state     <= S_STOP;
                        end else begin
                            r_bit_count <= r_bit_count + 1'b1;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_clk_count == LAST_CNT) begin
                        r_clk_count <= '0;
                        r_state     <= S_FINISH;
                        r_rx_busy   <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
                        if (w_rx_sync) begin
                            r_rx_data <= r_shift;
                            r_rx_done <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
`else
                        r_rx_data <= r_shift;
                        r_rx_done <= 1'b1;
`endif
                    end else begin
                        r_clk_count <= r_clk_count + 1'b1;
                    end
                end

                S_FINISH: begin
                    r_rx_done <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
                    r_frame_err <= 1'b0;
`endif
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_clk_count <= '0;
                    r_bit_count <= '0;
                    r_rx_done   <= 1'b0;
                    r_rx_busy   <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
                    r_frame_err <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx

module tb_uart_rx;

    localparam int CPB_A = 16;
    localparam int CPB_B = 87;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_a;
    logic       line_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       done_a;
    logic       done_b;
    logic       busy_a;
    logic       busy_b;
`ifdef UART_RX_FRAME_CHECK_EN
    logic       ferr_a;
    logic       ferr_b;
`endif

    always #5 clk = ~clk;

    uart_rx #(.DATA_LEN(8), .CLKS_PER_BIT(CPB_A)) u_dut_a (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_rx_line  (line_a),
        .o_rx_data  (data_a),
        .o_rx_done  (done_a),
        .o_rx_busy  (busy_a)
`ifdef UART_RX_FRAME_CHECK_EN
        ,
        .o_frame_err(ferr_a)
`endif
    );

    uart_rx #(.DATA_LEN(8), .CLKS_PER_BIT(CPB_B)) u_dut_b (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_rx_line  (line_b),
        .o_rx_data  (data_b),
        .o_rx_done  (done_b),
        .o_rx_busy  (busy_b)
`ifdef UART_RX_FRAME_CHECK_EN
        ,
        .o_frame_err(ferr_b)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] model_last_a;
    int         exp_dones_a;
    int         exp_ferr_a;

    // Observations
    int         dones_a;
    int         ferr_cnt_a;
    int         ferr_cnt_b;
    int         dones_b;
    logic [7:0] last_b;
    int         cyc;
    int         t_prev;
    int         t_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && done_a) begin
            dones_a++;
            t_prev = t_last;
            t_last = cyc;
            check_eq("done_has_expected_word", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_eq("rx_data_a", data_a, exp_q.pop_front());
        end
`ifdef UART_RX_FRAME_CHECK_EN
        if (!rst && ferr_a) ferr_cnt_a++;
        if (!rst && ferr_b) ferr_cnt_b++;
`endif
        if (!rst && done_b) begin
            dones_b++;
            last_b = data_b;
        end
    end

    task automatic idle(input int n);
        line_a = 1'b1;
        line_b = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; abort_bit >= 0 pulses reset in the middle of that data bit.
    task automatic send(input int sel, input logic [7:0] d, input logic stop,
                        input int blen, input int abort_bit);
        logic [9:0] bits;
        logic       good;
        bits = {stop, d, 1'b0};
`ifdef UART_RX_FRAME_CHECK_EN
        good = stop;
`else
        good = 1'b1;
`endif
        if (sel == 0) begin
            if (good) begin
                exp_q.push_back(d);
                model_last_a = d;
                if (abort_bit < 0) exp_dones_a++;
            end else begin
                exp_ferr_a++;
            end
        end
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < blen; c++) begin
                @(negedge clk);
                if (sel == 0) line_a = bits[b];
                else          line_b = bits[b];
                if (sel == 0 && b == 5 && c == blen / 2)
                    check_eq("busy_mid_frame", busy_a, 1);
                if (abort_bit >= 0 && b == abort_bit + 1 && c == blen / 2) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    line_a = 1'b1;
                    exp_q.delete();
                    model_last_a = 8'h00;
                    return;
                end
            end
        end
    endtask

    initial begin
        logic [7:0] r;
        logic       s;
        int         base;

        cyc = 0; t_prev = 0; t_last = 0;
        dones_a = 0; dones_b = 0; ferr_cnt_a = 0; ferr_cnt_b = 0;
        exp_dones_a = 0; exp_ferr_a = 0; model_last_a = 8'h00; last_b = 8'h00;
        rst = 1'b1;
        line_a = 1'b1;
        line_b = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("reset_rx_data", data_a, 8'h00);
        check_eq("reset_rx_done", done_a, 0);
        check_eq("reset_rx_busy", busy_a, 0);
`ifdef UART_RX_FRAME_CHECK_EN
        check_eq("reset_frame_err", ferr_a, 0);
`endif
        rst = 1'b0;
        idle(10);

        // Basic receive
        send(0, 8'hA5, 1'b1, CPB_A, -1);
        idle(20);
        check_eq("basic_dones", dones_a, 1);
        check_eq("basic_data", data_a, 8'hA5);
        check_eq("basic_busy_after", busy_a, 0);

        // Start glitch
        line_a = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check_eq("glitch_dones", dones_a, 1);
        check_eq("glitch_data", data_a, 8'hA5);
        check_eq("glitch_busy", busy_a, 0);

        // Back-to-back frames
        send(0, 8'h00, 1'b1, CPB_A, -1);
        send(0, 8'hFF, 1'b1, CPB_A, -1);
        idle(20);
        check_eq("b2b_dones", dones_a, 3);
        check_eq("b2b_gap", t_last - t_prev, 160);
        check_eq("b2b_data", data_a, 8'hFF);

        // Reset during data bit 3
        base = dones_a;
        send(0, 8'h3C, 1'b1, CPB_A, 3);
        check_eq("abort_busy", busy_a, 0);
        check_eq("abort_data", data_a, 8'h00);
        idle(200);
        check_eq("abort_no_done", dones_a, base);
        send(0, 8'h5A, 1'b1, CPB_A, -1);
        idle(20);
        check_eq("after_abort_data", data_a, 8'h5A);
        check_eq("after_abort_dones", dones_a, base + 1);

        // Framing error
        send(0, 8'h81, 1'b0, CPB_A, -1);
        idle(40);
`ifdef UART_RX_FRAME_CHECK_EN
        check_eq("ferr_data_held", data_a, 8'h5A);
        check_eq("ferr_pulses", ferr_cnt_a, 1);
        check_eq("ferr_no_done", dones_a, base + 1);
`else
        check_eq("badstop_data", data_a, 8'h81);
        check_eq("badstop_dones", dones_a, base + 2);
`endif

        // Randomized frames
        for (int i = 0; i < 20; i++) begin
            r = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send(0, r, s, CPB_A, -1);
            if (!s) idle(30);
            else    idle($urandom_range(0, 5));
        end
        idle(200);
        check_eq("rand_dones", dones_a, exp_dones_a);
        check_eq("rand_queue_drained", exp_q.size(), 0);
        check_eq("rand_last_data", data_a, model_last_a);
`ifdef UART_RX_FRAME_CHECK_EN
        check_eq("rand_ferr", ferr_cnt_a, exp_ferr_a);
`endif

        // Baud tolerance on the 87-clock instance
        send(1, 8'h55, 1'b1, 88, -1);
        idle(50);
        check_eq("tol88_dones", dones_b, 1);
        check_eq("tol88_data", last_b, 8'h55);
        send(1, 8'h55, 1'b1, 86, -1);
        idle(50);
        check_eq("tol86_dones", dones_b, 2);
        check_eq("tol86_data", data_b, 8'h55);
        r = 8'($urandom);
        send(1, r, 1'b1, 88, -1);
        idle(50);
        check_eq("tol88_rand_data", last_b, r);
        r = 8'($urandom);
        send(1, r, 1'b1, 86, -1);
        idle(50);
        check_eq("tol86_rand_data", last_b, r);
        check_eq("tol_dones_total", dones_b, 4);
        check_eq("tol_ferr_b", ferr_cnt_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver and counterpart of the bus UART transmitter.
- Frame format: 8N1 style. One start bit (0), DATA_LEN data bits LSB first, one stop bit (1), no parity.
- Oversamples the serial line at clk rate and samples each bit at its midpoint.
- Presents each received word in parallel with a one-cycle rx_done strobe, for bus-side slave logic.

Parameters:
- DATA_LEN, 8: data bits per frame.
- CLKS_PER_BIT, 87: clk cycles per bit, equal to f_clk / baud (10 MHz / 115200 = 87). Must be >= 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_line  in  1  asynchronous serial input; idle level is 1.
- rx_data  out  DATA_LEN  last correctly received word; holds until the next valid frame.
- rx_done  out  1  high for exactly one cycle when rx_data has been updated.
- rx_busy  out  1  high while a frame is being received (START_BIT through STOP_BIT).
- frame_err  out  1  present only with UART_RX_FRAME_CHECK_EN; see Optional Feature.

Behaviour:
- Reset (synchronous, sampled on clk rising edge):
  - Outputs: rx_data=0, rx_done=0, rx_busy=0, frame_err=0.
  - Internal: state=IDLE, clk_count=0, bit_count=0, shift register=0.
  - Both synchronizer flops are set to 1.
  - Reset mid-frame aborts the frame with no rx_done and leaves rx_data=0.
- Input sync: rx_line passes through a 2-flop synchronizer to give rx_sync. All decisions use rx_sync, which lags rx_line by 2 cycles.
- States and transitions:
  - IDLE: rx_busy=0, rx_done=0. When rx_sync==0, go to START_BIT with clk_count=0 and rx_busy=1.
  - START_BIT: clk_count increments each cycle. At clk_count==(CLKS_PER_BIT-1)/2 (integer divide), sample rx_sync:
    - If 0: go to DATA_BITS with clk_count=0 and bit_count=0. Every later sample is then one full bit period later, i.e. mid-bit.
    - If 1 (glitch): return to IDLE with rx_busy=0 and no rx_done.
  - DATA_BITS: at clk_count==CLKS_PER_BIT-1, store rx_sync in shift[bit_count] and set clk_count=0.
    - If bit_count < DATA_LEN-1: increment bit_count.
    - Otherwise: go to STOP_BIT with bit_count=0.
    - At all other counts, clk_count increments.
  - STOP_BIT: at clk_count==CLKS_PER_BIT-1, go to FINISH with clk_count=0 and rx_busy=0. rx_data is loaded from shift and rx_done=1 on the same edge.
  - FINISH: lasts one cycle. rx_done returns to 0 and the state returns to IDLE.
  - Undefined state codes go to IDLE and clear the counters.
- Latency: rx_done rises on the edge ending STOP_BIT's sample cycle. That is about (CLKS_PER_BIT-1)/2 + (DATA_LEN+1)·CLKS_PER_BIT + 3 clocks after the rx_line falling edge.
- Line held low (break): frames complete back-to-back with data 0x00, because IDLE re-triggers immediately while rx_sync stays 0.
- rx_data changes only on the rx_done edge and is stable otherwise. The consumer has one full frame time to read it.

Optional Feature:
- Macro: UART_RX_FRAME_CHECK_EN.
- Defined:
  - The frame_err port exists.
  - In STOP_BIT, if the sampled rx_sync==0, rx_data is NOT updated and rx_done stays 0.
  - Instead, frame_err is 1 for the single FINISH cycle.
  - A good stop bit behaves as in the base design, with frame_err=0.
- Not defined:
  - No frame_err port.
  - The stop-bit value is ignored.
  - rx_data is always loaded and rx_done always pulsed.

Test Plan:
- Basic receive: CLKS_PER_BIT=16, drive frame 0xA5 LSB first with 16-cycle bits. Expect exactly one rx_done pulse, rx_data=0xA5, and rx_busy high from start detect to the end of STOP_BIT.
- Back-to-back frames: 0x00 then 0xFF with no idle gap. Expect two rx_done pulses about 160 cycles apart, with rx_data=0x00 then 0xFF.
- Start glitch: rx_line low for 4 cycles, then high. Expect a return to IDLE, no rx_done, and rx_data unchanged.
- Reset mid-frame: assert reset for 1 cycle during data bit 3 of frame 0x3C. Expect rx_busy=0, rx_data=0 and no rx_done; the next full frame 0x5A is received correctly.
- Framing error (macro defined): send 0x81 with stop bit 0. Expect rx_done to stay 0, frame_err=1 for 1 cycle, and rx_data to keep its previous value. Without the macro, expect rx_done=1 and rx_data=0x81.
- Baud tolerance: CLKS_PER_BIT=87, transmit 0x55 at 88 and at 86 clocks per bit. Expect rx_data=0x55 in both cases.
